// File: rtl/stream_mux_arbiter_pkg.sv
// Shared constants for the stream mux: select-width helper and processor requester channel indices.
package stream_mux_arbiter_pkg;

    localparam int CH_FETCH      = 0;
    localparam int CH_LOAD_STORE = 1;
    localparam int CH_DEBUG      = 2;
    localparam int CH_SPARE      = 3;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stream_mux_arbiter_rr_arbiter.sv
// Round-robin arbiter: owns the rotating priority pointer and returns a one-hot grant plus its index.
module rr_arbiter
    import stream_mux_arbiter_pkg::*;
#(
    parameter int CHANNELS = 4,
    localparam int SEL_W   = sel_width(CHANNELS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] req,
    input  logic                advance,
    input  logic [SEL_W-1:0]    advance_idx,
    output logic [CHANNELS-1:0] grant,
    output logic [SEL_W-1:0]    grant_idx,
    output logic                grant_any
);

    logic [SEL_W-1:0] ptr;

    // Two passes: first requester at or above ptr, otherwise the first one below it (the wrap).
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (!grant_any && req[i] && (SEL_W'(i) >= ptr)) begin
                grant_any = 1'b1;
                grant[i]  = 1'b1;
                grant_idx = SEL_W'(i);
            end
        end
        for (int i = 0; i < CHANNELS; i++) begin
            if (!grant_any && req[i]) begin
                grant_any = 1'b1;
                grant[i]  = 1'b1;
                grant_idx = SEL_W'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (advance_idx == SEL_W'(CHANNELS - 1)) ? '0 : advance_idx + 1'b1;
        end
    end

endmodule

// File: rtl/stream_mux_arbiter.sv
// N-channel valid/ready stream mux with round-robin arbitration and a registered output stage.
// Optional packet locking (in_last/out_last ports) is enabled by defining STREAM_MUX_LOCK_EN.
module stream_mux_arbiter
    import stream_mux_arbiter_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4,
    localparam int SEL_W   = sel_width(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS*WIDTH-1:0] in_bus,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
`ifdef STREAM_MUX_LOCK_EN
    input  logic [CHANNELS-1:0]       in_last,
    output logic                      out_last,
`endif
    output logic [SEL_W-1:0]          out_sel
);

    // Handshake: a beat moves on channel i when in_valid[i] && in_ready[i] at a rising edge;
    // sources hold valid/data until accepted, in_ready may depend combinationally on out_ready.
    logic                load;
    logic                accept;
    logic                advance;
    logic [CHANNELS-1:0] req;
    logic [CHANNELS-1:0] grant;
    logic [SEL_W-1:0]    grant_idx;
    logic                grant_any;
    logic [WIDTH-1:0]    sel_data;

    assign load   = !out_valid || out_ready;
    assign accept = load && !reset && grant_any;

`ifdef STREAM_MUX_LOCK_EN
    logic                lock;
    logic [CHANNELS-1:0] lock_mask;
    logic                last_sel;

    // While locked only the owning channel may request; ptr moves only when the packet closes.
    assign req      = lock ? (in_valid & lock_mask) : in_valid;
    assign last_sel = |(in_last & grant);
    assign advance  = accept && last_sel;
`else
    assign req     = in_valid;
    assign advance = accept;
`endif

    assign in_ready = (load && !reset) ? grant : '0;

    rr_arbiter #(
        .CHANNELS (CHANNELS)
    ) u_rr (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .advance     (advance),
        .advance_idx (grant_idx),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_any   (grant_any)
    );

    // Channel 0 lives in the MSB slice of in_bus.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (grant[i]) begin
                sel_data = in_bus[(CHANNELS-i)*WIDTH-1 -: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
`ifdef STREAM_MUX_LOCK_EN
            out_last  <= 1'b0;
            lock      <= 1'b0;
            lock_mask <= '0;
`endif
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_sel   <= grant_idx;
`ifdef STREAM_MUX_LOCK_EN
            out_last  <= last_sel;
            lock      <= !last_sel;
            lock_mask <= grant;
`endif
        end else if (load) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_mux_arbiter.sv
// Directed bench for stream_mux_arbiter: a 4-channel instance plus a 3-channel instance for wrap cases.
module tb_stream_mux_arbiter;
    import stream_mux_arbiter_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic [127:0] in_bus;
    logic [3:0]   in_valid;
    logic [3:0]   in_ready;
    logic [31:0]  out_data;
    logic         out_valid;
    logic         out_ready;
    logic [1:0]   out_sel;

    logic [95:0]  in_bus3;
    logic [2:0]   in_valid3;
    logic [2:0]   in_ready3;
    logic [31:0]  out_data3;
    logic         out_valid3;
    logic         out_ready3;
    logic [1:0]   out_sel3;

`ifdef STREAM_MUX_LOCK_EN
    logic [3:0]   in_last;
    logic         out_last;
    logic [2:0]   in_last3;
    logic         out_last3;
`endif

    int n_vec = 0;
    int n_err = 0;

    stream_mux_arbiter #(.WIDTH(32), .CHANNELS(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_bus    (in_bus),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef STREAM_MUX_LOCK_EN
        .in_last   (in_last),
        .out_last  (out_last),
`endif
        .out_sel   (out_sel)
    );

    stream_mux_arbiter #(.WIDTH(32), .CHANNELS(3)) dut3 (
        .clk       (clk),
        .reset     (reset),
        .in_bus    (in_bus3),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .out_data  (out_data3),
        .out_valid (out_valid3),
        .out_ready (out_ready3),
`ifdef STREAM_MUX_LOCK_EN
        .in_last   (in_last3),
        .out_last  (out_last3),
`endif
        .out_sel   (out_sel3)
    );

    function automatic logic [31:0] dat4(input int ch);
        return 32'hA5A5_0000 + 32'(ch) * 32'h0101;
    endfunction

    function automatic logic [31:0] dat3(input int ch);
        return 32'h3C00_0000 + 32'(ch) * 32'h0011;
    endfunction

    task automatic do_reset();
        reset     = 1'b1;
        in_valid  = '0;
        in_valid3 = '0;
`ifdef STREAM_MUX_LOCK_EN
        in_last   = 4'b1111;
        in_last3  = 3'b111;
`endif
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        n_vec++;
        if (out_data !== 32'h0) begin n_err++; $display("FAIL reset_data: got %h expected 0", out_data); end
        n_vec++;
        if (out_sel !== 2'd0) begin n_err++; $display("FAIL reset_sel: got %0d expected 0", out_sel); end
        n_vec++;
        if (in_ready !== 4'b0000) begin n_err++; $display("FAIL reset_in_ready: got %b expected 0000", in_ready); end
`ifdef STREAM_MUX_LOCK_EN
        n_vec++;
        if (out_last !== 1'b0) begin n_err++; $display("FAIL reset_last: got %b expected 0", out_last); end
`endif
        reset = 1'b0;
        #1;
        n_vec++;
        if (in_ready !== 4'b0001) begin n_err++; $display("FAIL release_in_ready: got %b expected 0001", in_ready); end
        @(posedge clk);
        #1;
        n_vec++;
        if (out_valid !== 1'b1 || out_sel !== 2'(CH_FETCH) || out_data !== dat4(0)) begin
            n_err++;
            $display("FAIL release_first_beat: got v=%b sel=%0d d=%h expected v=1 sel=0 d=%h",
                     out_valid, out_sel, out_data, dat4(0));
        end
    endtask

    task automatic test_round_robin();
        int exp_seq[5] = '{0, 1, 2, 3, 0};
        do_reset();
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        #1;
        n_vec++;
        if (in_ready !== 4'b0001) begin n_err++; $display("FAIL rr_first_ready: got %b expected 0001", in_ready); end
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            n_vec++;
            if (out_valid !== 1'b1 || out_sel !== 2'(exp_seq[k]) || out_data !== dat4(exp_seq[k])) begin
                n_err++;
                $display("FAIL rr_beat%0d: got v=%b sel=%0d d=%h expected v=1 sel=%0d d=%h",
                         k, out_valid, out_sel, out_data, exp_seq[k], dat4(exp_seq[k]));
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        #1;
        n_vec++;
        if (in_ready !== 4'b0000) begin n_err++; $display("FAIL bp_in_ready: got %b expected 0000", in_ready); end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            n_vec++;
            if (out_valid !== 1'b1 || out_sel !== 2'd0 || out_data !== dat4(0) || in_ready !== 4'b0000) begin
                n_err++;
                $display("FAIL bp_hold%0d: got v=%b sel=%0d d=%h rdy=%b expected v=1 sel=0 d=%h rdy=0000",
                         k, out_valid, out_sel, out_data, in_ready, dat4(0));
            end
        end
        out_ready = 1'b1;
        #1;
        n_vec++;
        if (in_ready !== 4'b0010) begin n_err++; $display("FAIL bp_release_ready: got %b expected 0010", in_ready); end
        @(posedge clk);
        #1;
        n_vec++;
        if (out_valid !== 1'b1 || out_sel !== 2'd1 || out_data !== dat4(1)) begin
            n_err++;
            $display("FAIL bp_release_beat: got v=%b sel=%0d d=%h expected v=1 sel=1 d=%h",
                     out_valid, out_sel, out_data, dat4(1));
        end
    endtask

    task automatic test_wrap_sparse();
        int exp_seq[4] = '{2, 0, 2, 0};
        do_reset();
        in_bus3    = {dat3(0), dat3(1), dat3(2)};
        out_ready3 = 1'b1;
        in_valid3  = 3'b010;
        #1;
        n_vec++;
        if (in_ready3 !== 3'b010) begin n_err++; $display("FAIL wrap_setup_ready: got %b expected 010", in_ready3); end
        @(posedge clk);
        #1;
        in_valid3 = 3'b101;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            n_vec++;
            if (out_valid3 !== 1'b1 || out_sel3 !== 2'(exp_seq[k]) || out_data3 !== dat3(exp_seq[k])) begin
                n_err++;
                $display("FAIL wrap_beat%0d: got v=%b sel=%0d d=%h expected v=1 sel=%0d d=%h",
                         k, out_valid3, out_sel3, out_data3, exp_seq[k], dat3(exp_seq[k]));
            end
        end
        in_valid3 = 3'b000;
        #1;
        n_vec++;
        if (in_ready3 !== 3'b000) begin n_err++; $display("FAIL idle_ready: got %b expected 000", in_ready3); end
        @(posedge clk);
        #1;
        n_vec++;
        if (out_valid3 !== 1'b0) begin n_err++; $display("FAIL idle_valid: got %b expected 0", out_valid3); end
    endtask

`ifdef STREAM_MUX_LOCK_EN
    task automatic test_lock();
        do_reset();
        out_ready = 1'b1;
        in_valid  = 4'b0001;
        @(posedge clk);
        #1;
        in_valid = 4'b0111;
        for (int k = 0; k < 3; k++) begin
            in_last[1] = (k == 2);
            #1;
            n_vec++;
            if (in_ready !== 4'b0010) begin n_err++; $display("FAIL lock_ready%0d: got %b expected 0010", k, in_ready); end
            @(posedge clk);
            #1;
            n_vec++;
            if (out_sel !== 2'd1 || out_last !== (k == 2) || out_data !== dat4(1)) begin
                n_err++;
                $display("FAIL lock_beat%0d: got sel=%0d last=%b d=%h expected sel=1 last=%b d=%h",
                         k, out_sel, out_last, out_data, (k == 2), dat4(1));
            end
            if (k == 1) begin
                in_valid = 4'b0101;
                #1;
                n_vec++;
                if (in_ready !== 4'b0000) begin n_err++; $display("FAIL lock_gap_ready: got %b expected 0000", in_ready); end
                @(posedge clk);
                #1;
                n_vec++;
                if (out_valid !== 1'b0) begin n_err++; $display("FAIL lock_gap_valid: got %b expected 0", out_valid); end
                in_valid = 4'b0111;
            end
        end
        #1;
        n_vec++;
        if (in_ready !== 4'b0100) begin n_err++; $display("FAIL unlock_ready: got %b expected 0100", in_ready); end
        @(posedge clk);
        #1;
        n_vec++;
        if (out_sel !== 2'd2 || out_last !== 1'b1) begin
            n_err++;
            $display("FAIL unlock_beat: got sel=%0d last=%b expected sel=2 last=1", out_sel, out_last);
        end
    endtask
`endif

    task automatic test_async_reset_mid();
        do_reset();
        out_ready = 1'b1;
        in_valid  = 4'b0001;
        @(posedge clk);
        #1;
`ifdef STREAM_MUX_LOCK_EN
        in_last[1] = 1'b0;
`endif
        in_valid = 4'b0010;
        @(posedge clk);
        #1;
        n_vec++;
        if (out_sel !== 2'd1 || out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL mid_setup: got sel=%0d v=%b expected sel=1 v=1", out_sel, out_valid);
        end
        in_valid = 4'b0111;
        #2;
        reset = 1'b1;
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 4'b0000) begin
            n_err++;
            $display("FAIL mid_reset: got v=%b rdy=%b expected v=0 rdy=0000", out_valid, in_ready);
        end
        reset = 1'b0;
        #1;
        n_vec++;
        if (in_ready !== 4'b0001) begin n_err++; $display("FAIL mid_release_ready: got %b expected 0001", in_ready); end
        @(posedge clk);
        #1;
        n_vec++;
        if (out_sel !== 2'd0 || out_valid !== 1'b1 || out_data !== dat4(0)) begin
            n_err++;
            $display("FAIL mid_release_beat: got sel=%0d v=%b d=%h expected sel=0 v=1 d=%h",
                     out_sel, out_valid, out_data, dat4(0));
        end
    endtask

    initial begin
        reset      = 1'b1;
        in_bus     = {dat4(0), dat4(1), dat4(2), dat4(3)};
        in_valid   = '0;
        out_ready  = 1'b1;
        in_bus3    = {dat3(0), dat3(1), dat3(2)};
        in_valid3  = '0;
        out_ready3 = 1'b1;
`ifdef STREAM_MUX_LOCK_EN
        in_last    = 4'b1111;
        in_last3   = 3'b111;
`endif
        test_reset();
        test_round_robin();
        test_backpressure();
        test_wrap_sparse();
`ifdef STREAM_MUX_LOCK_EN
        test_lock();
`endif
        test_async_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
